// File: rtl/vmem_pkg.sv
// Shared types, constants and address/bit mapping helpers for the vmem pixel writer.
// Optional feature macro: VMEM_WRITER_XOR_EN adds a per-command toggle bit to vmem_cmd_t.
package vmem_pkg;

    localparam int VMEM_AW        = 14;
    localparam int VMEM_DW        = 12;
    localparam int BLOCK_PX       = 12;
    localparam int PLANE_PX       = 6;
    localparam int ROWS_PER_BLOCK = 6;
    localparam logic [2:0] PAL_IDX_LO = 3'b011;
    localparam logic [2:0] PAL_IDX_HI = 3'b111;

    typedef struct packed {
        logic               op;       // 0 = plot pixel, 1 = raw word write
        logic [4:0]         x_block;
        logic [3:0]         x_pixel;
        logic [5:0]         y_block;
        logic [2:0]         y_row;
        logic               value;
`ifdef VMEM_WRITER_XOR_EN
        logic               tgl;      // plot toggles the bit instead of writing value
`endif
        logic [VMEM_AW-1:0] addr;
        logic [VMEM_DW-1:0] data;
    } vmem_cmd_t;

    // Word address of a pixel: columns 0..5 sit in plane A, 6..11 in plane B;
    // pairs of rows share one word.
    function automatic logic [VMEM_AW-1:0] plot_addr(input logic [5:0] y_block,
                                                     input logic [4:0] x_block,
                                                     input logic [3:0] x_pixel,
                                                     input logic [2:0] y_row);
        return {y_block, x_block, (x_pixel >= 4'(PLANE_PX)), y_row[2:1]};
    endfunction

    // Bit position inside the word: odd rows use the upper six bits.
    function automatic logic [3:0] plot_bit(input logic [3:0] x_pixel,
                                            input logic [2:0] y_row);
        logic [3:0] col;
        col = (x_pixel >= 4'(PLANE_PX)) ? (x_pixel - 4'(PLANE_PX)) : x_pixel;
        return col + (y_row[0] ? 4'(PLANE_PX) : 4'd0);
    endfunction

endpackage

// File: rtl/vmem_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; depth must be a power of two.
module vmem_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vmem_pixel_writer.sv
// Write-side vmem client: queues plot/raw commands and performs read-modify-write
// on 12-bit plane words whenever the video generator grants the port.
// Optional feature macro: VMEM_WRITER_XOR_EN (plots may toggle the target bit).
module vmem_pixel_writer
    import vmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int Y_BLOCKS   = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [4:0]  cmd_x_block,
    input  logic [3:0]  cmd_x_pixel,
    input  logic [5:0]  cmd_y_block,
    input  logic [2:0]  cmd_y_row,
    input  logic        cmd_value,
    input  logic [13:0] cmd_addr,
    input  logic [11:0] cmd_data,
    input  logic        cmd_xor,
    input  logic        vmem_grant,
    output logic [13:0] vmem_addr,
    output logic [11:0] vmem_wdata,
    output logic        vmem_we,
    output logic        vmem_re,
    input  logic [11:0] vmem_rdata,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE} state_t;

    state_t             state;
    state_t             state_nx;
    vmem_cmd_t          cmd_in;
    vmem_cmd_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               head_bad;
    logic [VMEM_AW-1:0] addr_r;
    logic [VMEM_DW-1:0] word_r;
    logic [3:0]         bit_r;
    logic               val_r;
    logic               tgl_r;
    logic               done_r;

    // Set, clear or toggle one bit of a captured word.
    function automatic logic [VMEM_DW-1:0] apply_bit(input logic [VMEM_DW-1:0] w,
                                                     input logic [3:0] idx,
                                                     input logic v,
                                                     input logic t);
        logic [VMEM_DW-1:0] mask;
        mask = VMEM_DW'(1) << idx;
        if (t)      return w ^ mask;
        else if (v) return w | mask;
        else        return w & ~mask;
    endfunction

    // Pack the incoming command; the toggle bit only exists when the feature is built.
    always_comb begin
        cmd_in         = '0;
        cmd_in.op      = cmd_op;
        cmd_in.x_block = cmd_x_block;
        cmd_in.x_pixel = cmd_x_pixel;
        cmd_in.y_block = cmd_y_block;
        cmd_in.y_row   = cmd_y_row;
        cmd_in.value   = cmd_value;
`ifdef VMEM_WRITER_XOR_EN
        cmd_in.tgl     = cmd_xor;
`endif
        cmd_in.addr    = cmd_addr;
        cmd_in.data    = cmd_data;
    end

`ifndef VMEM_WRITER_XOR_EN
    logic unused_xor;
    assign unused_xor = cmd_xor;
`endif

    assign cmd_ready = !fifo_full;

    vmem_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     ($bits(vmem_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Out-of-range plot coordinates are rejected at pop time; raw ops are never rejected.
    assign head_bad = !head.op &&
                      ((head.x_pixel >= 4'(BLOCK_PX)) ||
                       (head.y_row >= 3'(ROWS_PER_BLOCK)) ||
                       (int'(head.y_block) >= Y_BLOCKS));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state and port strobes; strobes only ever fire in a granted cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        err      = 1'b0;
        vmem_re  = 1'b0;
        vmem_we  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_bad)     err      = 1'b1;
                    else if (head.op) state_nx = S_WRITE;
                    else              state_nx = S_READ;
                end
            end
            S_READ: begin
                if (vmem_grant) begin
                    vmem_re  = 1'b1;
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: state_nx = S_WRITE;
            S_WRITE: begin
                if (vmem_grant) begin
                    vmem_we  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Working word: loaded on pop, merged with read data in CAPTURE, held through grant loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= '0;
            word_r <= '0;
            bit_r  <= '0;
            val_r  <= 1'b0;
            tgl_r  <= 1'b0;
        end else if (pop && !head_bad) begin
            addr_r <= head.op ? head.addr
                              : plot_addr(head.y_block, head.x_block, head.x_pixel, head.y_row);
            word_r <= head.data;
            bit_r  <= plot_bit(head.x_pixel, head.y_row);
            val_r  <= head.value;
`ifdef VMEM_WRITER_XOR_EN
            tgl_r  <= head.tgl;
`else
            tgl_r  <= 1'b0;
`endif
        end else if (state == S_CAPTURE) begin
            word_r <= apply_bit(vmem_rdata, bit_r, val_r, tgl_r);
        end
    end

    // Completion pulse lands the cycle after the write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_r <= 1'b0;
        else     done_r <= vmem_we;
    end

    assign vmem_addr  = addr_r;
    assign vmem_wdata = word_r;
    assign done       = done_r;
    assign busy       = !fifo_empty || (state != S_IDLE) || done_r;

endmodule

// File: tb/tb_vmem_pixel_writer.sv
// Directed bench for vmem_pixel_writer with a vmem model and a write scoreboard.
`timescale 1ns/1ps
module tb_vmem_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op, cmd_value, cmd_xor;
    logic [4:0]  cmd_x_block;
    logic [3:0]  cmd_x_pixel;
    logic [5:0]  cmd_y_block;
    logic [2:0]  cmd_y_row;
    logic [13:0] cmd_addr;
    logic [11:0] cmd_data;
    logic        vmem_grant, vmem_we, vmem_re, done, err, busy;
    logic [13:0] vmem_addr;
    logic [11:0] vmem_wdata;
    logic [11:0] vmem_rdata = 12'h000;

    vmem_pixel_writer #(.FIFO_DEPTH(4), .Y_BLOCKS(48)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x_block(cmd_x_block), .cmd_x_pixel(cmd_x_pixel),
        .cmd_y_block(cmd_y_block), .cmd_y_row(cmd_y_row),
        .cmd_value(cmd_value), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_xor(cmd_xor), .vmem_grant(vmem_grant),
        .vmem_addr(vmem_addr), .vmem_wdata(vmem_wdata),
        .vmem_we(vmem_we), .vmem_re(vmem_re), .vmem_rdata(vmem_rdata),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_we_cyc = 0;
    int re_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0;

    typedef struct { logic [13:0] a; logic [11:0] d; } wr_t;
    wr_t exp_q[$];

    logic [11:0] mem    [logic [13:0]];
    logic [11:0] shadow [logic [13:0]];

    function automatic logic [11:0] mrd(input logic [13:0] a);
        return mem.exists(a) ? mem[a] : 12'h000;
    endfunction

    function automatic logic [11:0] srd(input logic [13:0] a);
        return shadow.exists(a) ? shadow[a] : 12'h000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // vmem model: read data appears one cycle after the address, writes land at the edge.
    always @(posedge clk) vmem_rdata <= mrd(vmem_addr);
    always @(posedge clk) if (vmem_we) mem[vmem_addr] = vmem_wdata;

    // Port monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (vmem_re || vmem_we) begin
                check("port_grant", vmem_grant, 1);
                check("re_we_excl", vmem_re & vmem_we, 0);
            end
            if (vmem_re) re_cnt++;
            if (vmem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", vmem_addr, e.a);
                    check("wr_data", vmem_wdata, e.d);
                end
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    end

    task automatic send(input logic op, input logic [4:0] xb, input logic [3:0] xp,
                        input logic [5:0] yb, input logic [2:0] yr, input logic v,
                        input logic t, input logic [13:0] a, input logic [11:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cmd_op = op; cmd_x_block = xb; cmd_x_pixel = xp; cmd_y_block = yb;
        cmd_y_row = yr; cmd_value = v; cmd_xor = t; cmd_addr = a; cmd_data = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", cmd_ready, 1);
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
        cmd_valid = 1'b0;
    endtask

    // Expected effect of a plot, from the pixel-to-word mapping.
    task automatic plot(input logic [4:0] xb, input logic [3:0] xp, input logic [5:0] yb,
                        input logic [2:0] yr, input logic v, input logic t);
        logic [13:0] a;
        int          b;
        logic [11:0] w;
        wr_t         e;
        if (xp <= 11 && yr <= 5 && yb < 48) begin
            a = {yb, xb, (xp >= 6), yr[2:1]};
            b = (yr[0] ? 6 : 0) + ((xp >= 6) ? int'(xp) - 6 : int'(xp));
            w = srd(a);
`ifdef VMEM_WRITER_XOR_EN
            if (t) w[b] = ~w[b];
            else   w[b] = v;
`else
            w[b] = v;
`endif
            shadow[a] = w;
            e.a = a; e.d = w;
            exp_q.push_back(e);
        end
        send(1'b0, xb, xp, yb, yr, v, t, 14'h0, 12'h0);
    endtask

    task automatic raw(input logic [13:0] a, input logic [11:0] d);
        wr_t e;
        shadow[a] = d;
        e.a = a; e.d = d;
        exp_q.push_back(e);
        send(1'b1, 5'd0, 4'd0, 6'd0, 3'd0, 1'b0, 1'b0, a, d);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic preload(input logic [13:0] a, input logic [11:0] d);
        mem[a] = d;
        shadow[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0, r0, e0, n;
        rst = 1'b1; vmem_grant = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_x_block = '0; cmd_x_pixel = '0; cmd_y_block = '0; cmd_y_row = '0;
        cmd_value = 1'b0; cmd_xor = 1'b0; cmd_addr = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_we", vmem_we, 0);
        check("rst_re", vmem_re, 0);
        check("rst_addr", vmem_addr, 0);
        check("rst_wdata", vmem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Plot x_block=3 x_pixel=8 y_block=5 y_row=3: word {5,3,1,2'b01}=0x051D, bit 6+2=8.
        w0 = we_cnt; d0 = done_cnt; r0 = re_cnt;
        plot(5'd3, 4'd8, 6'd5, 3'd3, 1'b1, 1'b0);
        wait_idle("t1_idle");
        check("t1_latency", last_we_cyc - acc_cyc, 3);
        check("t1_reads", re_cnt - r0, 1);
        check("t1_writes", we_cnt - w0, 1);
        check("t1_done", done_cnt - d0, 1);
        check("t1_mem", mrd(14'h051D), 12'h100);

        // Same pixel cleared over an all-ones word.
        preload(14'h051D, 12'hFFF);
        plot(5'd3, 4'd8, 6'd5, 3'd3, 1'b0, 1'b0);
        wait_idle("t2_idle");
        check("t2_mem", mrd(14'h051D), 12'hEFF);

        // Grant withdrawn right after the read; the latched word must be written later.
        preload({6'd10, 5'd7, 1'b0, 2'b10}, 12'h0A1);
        plot(5'd7, 4'd2, 6'd10, 3'd4, 1'b1, 1'b0);
        n = 0;
        while (!vmem_re && n < 50) begin @(negedge clk); n++; end
        check("t3_read_seen", vmem_re, 1);
        @(posedge clk); #1;
        vmem_grant = 1'b0;
        mem[{6'd10, 5'd7, 1'b0, 2'b10}] = 12'h555;
        w0 = we_cnt; r0 = re_cnt;
        repeat (20) @(negedge clk);
        check("t3_no_write", we_cnt - w0, 0);
        check("t3_busy", busy, 1);
        vmem_grant = 1'b1;
        wait_idle("t3_idle");
        check("t3_one_write", we_cnt - w0, 1);
        check("t3_no_reread", re_cnt - r0, 0);

        // Back-pressure: one command held by the FSM plus four queued fill the block.
        vmem_grant = 1'b0;
        w0 = we_cnt; d0 = done_cnt;
        for (int i = 0; i < 5; i++) raw(14'h0100 + 14'(i), 12'h010 + 12'(i));
        @(negedge clk);
        check("t4_ready_low", cmd_ready, 0);
        repeat (3) @(negedge clk);
        check("t4_ready_held", cmd_ready, 0);
        check("t4_no_write", we_cnt - w0, 0);
        vmem_grant = 1'b1;
        wait_idle("t4_idle");
        check("t4_writes", we_cnt - w0, 5);
        check("t4_done", done_cnt - d0, 5);

        // Rejected plots: pixel column 12, y_block 48, row 6.
        e0 = err_cnt; r0 = re_cnt; w0 = we_cnt;
        plot(5'd1, 4'd12, 6'd2, 3'd0, 1'b1, 1'b0);
        plot(5'd1, 4'd3, 6'd48, 3'd0, 1'b1, 1'b0);
        plot(5'd1, 4'd3, 6'd2, 3'd6, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_errs", err_cnt - e0, 3);
        check("t5_no_read", re_cnt - r0, 0);
        check("t5_no_write", we_cnt - w0, 0);
        plot(5'd31, 4'd11, 6'd47, 3'd5, 1'b1, 1'b0);
        wait_idle("t5_idle");
        check("t5_next_write", we_cnt - w0, 1);
        check("t5_mem", mrd({6'd47, 5'd31, 1'b1, 2'b10}), 12'h800);

        // Raw word write: no read, one-cycle pop-to-write.
        r0 = re_cnt; w0 = we_cnt;
        raw(14'h3003, 12'hABC);
        wait_idle("t6_idle");
        check("t6_no_read", re_cnt - r0, 0);
        check("t6_writes", we_cnt - w0, 1);
        check("t6_latency", last_we_cyc - acc_cyc, 1);
        check("t6_mem", mrd(14'h3003), 12'hABC);

`ifdef VMEM_WRITER_XOR_EN
        preload({6'd9, 5'd4, 1'b0, 2'b00}, 12'h123);
        plot(5'd4, 4'd1, 6'd9, 3'd1, 1'b0, 1'b1);
        wait_idle("t7_idle1");
        check("t7_toggled", mrd({6'd9, 5'd4, 1'b0, 2'b00}), 12'h1A3);
        plot(5'd4, 4'd1, 6'd9, 3'd1, 1'b1, 1'b1);
        wait_idle("t7_idle2");
        check("t7_restored", mrd({6'd9, 5'd4, 1'b0, 2'b00}), 12'h123);
`endif

        // Reset while a write waits for grant, with another command queued.
        vmem_grant = 1'b0;
        raw(14'h1111, 12'h111);
        raw(14'h2222, 12'h222);
        repeat (3) @(negedge clk);
        check("t8_busy_before", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        vmem_grant = 1'b1;
        #1;
        check("t8_we_in_rst", vmem_we, 0);
        @(negedge clk);
        check("t8_busy_in_rst", busy, 0);
        rst = 1'b0;
        w0 = we_cnt;
        repeat (10) @(negedge clk);
        check("t8_no_write", we_cnt - w0, 0);
        check("t8_busy", busy, 0);
        check("t8_ready", cmd_ready, 1);
        check("t8_mem_untouched", mrd(14'h1111), 12'h000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
